// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter for a shared FPU. Results are routed back to the
// issuing requester in issue order through a small requester-ID FIFO.
module fpu_issue_arbiter #(
   parameter  int unsigned NUM_REQ         = 2,
   parameter  int unsigned MAX_INFLIGHT    = 4,
   parameter  int unsigned EU_CTL_LEN      = 4,
   localparam int unsigned FLEN            = 64,
   localparam int unsigned FCSR_FRM_LEN    = 3,
   localparam int unsigned ROB_IDX_LEN     = 5,
   localparam int unsigned FFLAGS_LEN      = 5,
   localparam int unsigned EXCEPT_CODE_LEN = 6
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   flush_i,
   input  logic [NUM_REQ-1:0]                     req_valid_i,
   output logic [NUM_REQ-1:0]                     req_ready_o,
   input  logic [NUM_REQ-1:0][EU_CTL_LEN-1:0]     req_ctl_i,
   input  logic [NUM_REQ-1:0][FCSR_FRM_LEN-1:0]   req_rm_i,
   input  logic [NUM_REQ-1:0][ROB_IDX_LEN-1:0]    req_rob_idx_i,
   input  logic [NUM_REQ-1:0][FLEN-1:0]           req_rs1_value_i,
   input  logic [NUM_REQ-1:0][FLEN-1:0]           req_rs2_value_i,
   input  logic [NUM_REQ-1:0][FLEN-1:0]           req_rs3_value_i,
   output logic                                   fpu_valid_o,
   input  logic                                   fpu_ready_i,
   output logic [EU_CTL_LEN-1:0]                  fpu_ctl_o,
   output logic [FCSR_FRM_LEN-1:0]                fpu_rm_o,
   output logic [ROB_IDX_LEN-1:0]                 fpu_rob_idx_o,
   output logic [FLEN-1:0]                        fpu_rs1_value_o,
   output logic [FLEN-1:0]                        fpu_rs2_value_o,
   output logic [FLEN-1:0]                        fpu_rs3_value_o,
   input  logic                                   fpu_valid_i,
   output logic                                   fpu_ready_o,
   input  logic [ROB_IDX_LEN-1:0]                 fpu_rob_idx_i,
   input  logic [FLEN-1:0]                        fpu_result_i,
   input  logic [FFLAGS_LEN-1:0]                  fpu_fflags_i,
   input  logic                                   fpu_except_raised_i,
   input  logic [EXCEPT_CODE_LEN-1:0]             fpu_except_code_i,
   output logic [NUM_REQ-1:0]                     res_valid_o,
   input  logic [NUM_REQ-1:0]                     res_ready_i,
   output logic [ROB_IDX_LEN-1:0]                 res_rob_idx_o,
   output logic [FLEN-1:0]                        res_result_o,
   output logic [FFLAGS_LEN-1:0]                  res_fflags_o,
   output logic                                   res_except_raised_o,
   output logic [EXCEPT_CODE_LEN-1:0]             res_except_code_o
);

   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

   localparam logic [EU_CTL_LEN-1:0] FPU_DIV_S  = EU_CTL_LEN'(3);
   localparam logic [EU_CTL_LEN-1:0] FPU_SQRT_S = EU_CTL_LEN'(4);
   localparam logic [EU_CTL_LEN-1:0] FPU_DIV_D  = EU_CTL_LEN'(11);
   localparam logic [EU_CTL_LEN-1:0] FPU_SQRT_D = EU_CTL_LEN'(12);

   typedef enum logic {NORMAL, LONG} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   fifo_q [MAX_INFLIGHT];

   logic              active;
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W-1:0]   cand;
   logic              is_long;
   logic              issue_ok;
   logic              issue;
   logic              pop;
   logic              nonempty;
   logic [ID_W-1:0]   head_id;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign active = rst_ni & ~flush_i;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!gnt_found && req_valid_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign fpu_ctl_o       = req_ctl_i[gnt_idx];
   assign fpu_rm_o        = req_rm_i[gnt_idx];
   assign fpu_rob_idx_o   = req_rob_idx_i[gnt_idx];
   assign fpu_rs1_value_o = req_rs1_value_i[gnt_idx];
   assign fpu_rs2_value_o = req_rs2_value_i[gnt_idx];
   assign fpu_rs3_value_o = req_rs3_value_i[gnt_idx];

   assign is_long = (fpu_ctl_o == FPU_DIV_D) || (fpu_ctl_o == FPU_SQRT_D) ||
                    (fpu_ctl_o == FPU_DIV_S) || (fpu_ctl_o == FPU_SQRT_S);

   // A blocked grantee still holds the grant, so later requesters cannot bypass it.
   always_comb begin
      issue_ok = 1'b0;
      if (state_q == NORMAL)
         issue_ok = is_long ? (cnt_q == '0) : (cnt_q < CNT_W'(MAX_INFLIGHT));
   end

   assign fpu_valid_o = active & gnt_found & issue_ok;
   assign issue       = fpu_valid_o & fpu_ready_i;

   always_comb begin
      req_ready_o = '0;
      req_ready_o[gnt_idx] = fpu_valid_o & fpu_ready_i;
   end

   assign nonempty    = (cnt_q != '0);
   assign head_id     = fifo_q[rd_ptr_q];
   assign fpu_ready_o = active & nonempty & res_ready_i[head_id];
   assign pop         = fpu_valid_i & fpu_ready_o;

   always_comb begin
      res_valid_o = '0;
      res_valid_o[head_id] = active & nonempty & fpu_valid_i;
   end

   assign res_rob_idx_o       = fpu_rob_idx_i;
   assign res_result_o        = fpu_result_i;
   assign res_fflags_o        = fpu_fflags_i;
   assign res_except_raised_o = fpu_except_raised_i;
   assign res_except_code_o   = fpu_except_code_i;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      state_d  = state_q;
      if (issue) begin
         rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
         wr_ptr_d = ptr_inc(wr_ptr_q);
         if (is_long) state_d = LONG;
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         if ((state_q == LONG) && (cnt_q == CNT_W'(1))) state_d = NORMAL;
      end
      if (issue && !pop)
         cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !issue)
         cnt_d = cnt_q - CNT_W'(1);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
         state_d  = NORMAL;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         state_q  <= NORMAL;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         if (issue) fifo_q[wr_ptr_q] <= gnt_idx;
      end
   end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomized bench for fpu_issue_arbiter against a queue-based reference model.
module tb_fpu_issue_arbiter;

   localparam int NR = 2;
   localparam int MI = 4;

   localparam logic [3:0] ADD_S  = 4'd0;
   localparam logic [3:0] SUB_S  = 4'd1;
   localparam logic [3:0] MUL_S  = 4'd2;
   localparam logic [3:0] DIV_S  = 4'd3;
   localparam logic [3:0] SQRT_S = 4'd4;
   localparam logic [3:0] ADD_D  = 4'd8;
   localparam logic [3:0] MUL_D  = 4'd10;
   localparam logic [3:0] DIV_D  = 4'd11;
   localparam logic [3:0] SQRT_D = 4'd12;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                flush;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_ready;
   logic [NR-1:0][3:0]  req_ctl;
   logic [NR-1:0][2:0]  req_rm;
   logic [NR-1:0][4:0]  req_rob;
   logic [NR-1:0][63:0] req_rs1, req_rs2, req_rs3;
   logic                fpu_valid_o, fpu_ready_i;
   logic [3:0]          fpu_ctl;
   logic [2:0]          fpu_rm;
   logic [4:0]          fpu_rob_o;
   logic [63:0]         fpu_rs1, fpu_rs2, fpu_rs3;
   logic                fpu_valid_i, fpu_ready_o;
   logic [4:0]          fpu_rob_i;
   logic [63:0]         fpu_result;
   logic [4:0]          fpu_fflags;
   logic                fpu_exc;
   logic [5:0]          fpu_exc_code;
   logic [NR-1:0]       res_valid, res_ready;
   logic [4:0]          res_rob;
   logic [63:0]         res_result;
   logic [4:0]          res_fflags;
   logic                res_exc;
   logic [5:0]          res_exc_code;

   fpu_issue_arbiter #(.NUM_REQ(NR), .MAX_INFLIGHT(MI), .EU_CTL_LEN(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ctl_i(req_ctl),
      .req_rm_i(req_rm), .req_rob_idx_i(req_rob),
      .req_rs1_value_i(req_rs1), .req_rs2_value_i(req_rs2), .req_rs3_value_i(req_rs3),
      .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_ctl_o(fpu_ctl),
      .fpu_rm_o(fpu_rm), .fpu_rob_idx_o(fpu_rob_o),
      .fpu_rs1_value_o(fpu_rs1), .fpu_rs2_value_o(fpu_rs2), .fpu_rs3_value_o(fpu_rs3),
      .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_rob_idx_i(fpu_rob_i),
      .fpu_result_i(fpu_result), .fpu_fflags_i(fpu_fflags),
      .fpu_except_raised_i(fpu_exc), .fpu_except_code_i(fpu_exc_code),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_rob_idx_o(res_rob),
      .res_result_o(res_result), .res_fflags_o(res_fflags),
      .res_except_raised_o(res_exc), .res_except_code_o(res_exc_code)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit long_op(input logic [3:0] c);
      return c inside {DIV_D, SQRT_D, DIV_S, SQRT_S};
   endfunction

   function automatic logic [3:0] pick_ctl(input int long_pct);
      if ($urandom_range(99) < long_pct) begin
         case ($urandom_range(3))
            0: return DIV_D;
            1: return SQRT_D;
            2: return DIV_S;
            default: return SQRT_S;
         endcase
      end
      case ($urandom_range(4))
         0: return ADD_S;
         1: return SUB_S;
         2: return MUL_S;
         3: return ADD_D;
         default: return MUL_D;
      endcase
   endfunction

   // Reference model: ordered list of outstanding requester IDs.
   int idq[$];
   int rr;
   bit long_m;

   task automatic run_phase(input int ncyc, input int vld_pct, input int long_pct,
                            input int frdy_pct, input int fvld_pct, input int rrdy_pct,
                            input int flush_pct, input int rst_pct, input bit fixed_add);
      bit          active, found, lng, perm, e_fv, nonempty;
      int          g, hd;
      logic [NR-1:0] e_rr, e_resv;
      bit          e_fr;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk);
         #1;
         rst_n       = !($urandom_range(99) < rst_pct);
         flush       = ($urandom_range(99) < flush_pct);
         fpu_ready_i = ($urandom_range(99) < frdy_pct);
         fpu_valid_i = ($urandom_range(99) < fvld_pct);
         for (int k = 0; k < NR; k++) begin
            req_valid[k] = ($urandom_range(99) < vld_pct);
            req_ctl[k]   = fixed_add ? ADD_D : pick_ctl(long_pct);
            req_rm[k]    = 3'($urandom);
            req_rob[k]   = 5'($urandom);
            req_rs1[k]   = {$urandom, $urandom};
            req_rs2[k]   = {$urandom, $urandom};
            req_rs3[k]   = {$urandom, $urandom};
            res_ready[k] = ($urandom_range(99) < rrdy_pct);
         end
         fpu_rob_i    = 5'($urandom);
         fpu_result   = {$urandom, $urandom};
         fpu_fflags   = 5'($urandom);
         fpu_exc      = 1'($urandom);
         fpu_exc_code = 6'($urandom);

         @(negedge clk);
         active = rst_n && !flush;
         found  = 0;
         g      = 0;
         for (int k = 0; k < NR; k++) begin
            int c;
            c = (rr + k) % NR;
            if (!found && req_valid[c]) begin
               found = 1;
               g     = c;
            end
         end
         lng      = found && long_op(req_ctl[g]);
         perm     = !long_m && (lng ? (idq.size() == 0) : (idq.size() < MI));
         e_fv     = active && found && perm;
         e_rr     = (e_fv && fpu_ready_i) ? NR'(1 << g) : '0;
         nonempty = (idq.size() > 0);
         hd       = nonempty ? idq[0] : 0;
         e_fr     = active && nonempty && res_ready[hd];
         e_resv   = (active && nonempty && fpu_valid_i) ? NR'(1 << hd) : '0;

         check_eq("fpu_valid_o", 64'(fpu_valid_o), 64'(e_fv));
         check_eq("req_ready_o", 64'(req_ready), 64'(e_rr));
         check_eq("fpu_ready_o", 64'(fpu_ready_o), 64'(e_fr));
         check_eq("res_valid_o", 64'(res_valid), 64'(e_resv));
         if (e_fv) begin
            check_eq("fpu_ctl_o", 64'(fpu_ctl), 64'(req_ctl[g]));
            check_eq("fpu_rm_o", 64'(fpu_rm), 64'(req_rm[g]));
            check_eq("fpu_rob_idx_o", 64'(fpu_rob_o), 64'(req_rob[g]));
            check_eq("fpu_rs1_value_o", fpu_rs1, req_rs1[g]);
            check_eq("fpu_rs2_value_o", fpu_rs2, req_rs2[g]);
            check_eq("fpu_rs3_value_o", fpu_rs3, req_rs3[g]);
         end
         check_eq("res_result_o", res_result, fpu_result);
         check_eq("res_rob_idx_o", 64'(res_rob), 64'(fpu_rob_i));
         check_eq("res_fflags_o", 64'(res_fflags), 64'(fpu_fflags));
         check_eq("res_except", 64'({res_exc, res_exc_code}), 64'({fpu_exc, fpu_exc_code}));

         if (!rst_n) begin
            idq.delete();
            rr     = 0;
            long_m = 0;
         end else if (flush) begin
            idq.delete();
            long_m = 0;
         end else begin
            if (fpu_valid_i && e_fr) begin
               void'(idq.pop_front());
               if (long_m && idq.size() == 0) long_m = 0;
            end
            if (e_fv && fpu_ready_i) begin
               idq.push_back(g);
               rr = (g + 1) % NR;
               if (lng) long_m = 1;
            end
         end
      end
   endtask

   initial begin
      idq.delete();
      rr     = 0;
      long_m = 0;
      rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_ctl = '0; req_rm = '0; req_rob = '0;
      req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; fpu_ready_i = 1'b0; fpu_valid_i = 1'b0;
      res_ready = '0; fpu_rob_i = '0; fpu_result = '0; fpu_fflags = '0; fpu_exc = 1'b0;
      fpu_exc_code = '0;
      //          ncyc vld long frdy fvld rrdy flush rst  fixed_add
      run_phase(    3, 100,   0, 100, 100, 100,    0, 100, 1'b0); // held in reset
      run_phase(  200, 100,   0, 100, 100, 100,    0,   0, 1'b1); // alternating ADD_D
      run_phase(  300,  70,   0,  90,  10,  80,    0,   0, 1'b0); // fill to MAX_INFLIGHT
      run_phase(  400,  80,  35,  80,  40,  70,    0,   0, 1'b0); // long-op blocking
      run_phase(  400,  70,  25,  80,  50,  50,    0,   0, 1'b0); // head back-pressure
      run_phase(  600,  75,  30,  80,  40,  70,    6,   3, 1'b0); // flush and reset mid-stream
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
